// File: rtl/qdrc_user_arb.sv
// qdrc_user_arb
//   Two-port round-robin arbiter in front of a single QDR PHY user port.
//   It issues at most one command per cycle, and only while the PHY
//   reports ready. A read-tag pipeline, RD_LATENCY deep, steers returned
//   read data back to the port that issued the read.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   phy_rdy             PHY calibration complete; gates all grants
//   a_cmd_* / b_cmd_*   requester command (valid/rnw/addr/wr_data/wr_ben)
//                       and its single-cycle ack
//   a_rd_* / b_rd_*     registered read data with a one-cycle valid pulse
//   phy_*               PHY user port (registered address/data/strobes,
//                       read data input)
//   rd_inflight         count of issued reads whose data has not returned
module qdrc_user_arb #(
   parameter int DATA_WIDTH = 18,
   parameter int BW_WIDTH   = 2,
   parameter int ADDR_WIDTH = 21,
   parameter int RD_LATENCY = 10
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              phy_rdy,

   input  logic                              a_cmd_valid,
   input  logic                              a_cmd_rnw,
   input  logic [ADDR_WIDTH-1:0]             a_cmd_addr,
   input  logic [2*DATA_WIDTH-1:0]           a_cmd_wr_data,
   input  logic [2*BW_WIDTH-1:0]             a_cmd_wr_ben,
   output logic                              a_cmd_ack,
   output logic [2*DATA_WIDTH-1:0]           a_rd_data,
   output logic                              a_rd_dvld,

   input  logic                              b_cmd_valid,
   input  logic                              b_cmd_rnw,
   input  logic [ADDR_WIDTH-1:0]             b_cmd_addr,
   input  logic [2*DATA_WIDTH-1:0]           b_cmd_wr_data,
   input  logic [2*BW_WIDTH-1:0]             b_cmd_wr_ben,
   output logic                              b_cmd_ack,
   output logic [2*DATA_WIDTH-1:0]           b_rd_data,
   output logic                              b_rd_dvld,

   output logic [ADDR_WIDTH-1:0]             phy_addr,
   output logic                              phy_wr_strb,
   output logic [2*DATA_WIDTH-1:0]           phy_wr_data,
   output logic [2*BW_WIDTH-1:0]             phy_wr_ben,
   output logic                              phy_rd_strb,
   input  logic [2*DATA_WIDTH-1:0]           phy_rd_data,
   output logic [$clog2(RD_LATENCY+1)-1:0]   rd_inflight
);

   localparam int CNT_W = $clog2(RD_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // last_b = 1 means B won the previous grant, so A has priority next.
   logic                    last_b;
   logic                    arb_en;
   logic                    grant_a;
   logic                    grant_b;
   logic                    grant;

   logic                    win_rnw;
   logic [ADDR_WIDTH-1:0]   win_addr;
   logic [2*DATA_WIDTH-1:0] win_wr_data;
   logic [2*BW_WIDTH-1:0]   win_wr_ben;

   // Port that owns the read currently on phy_rd_strb.
   logic                    issued_b;

   logic [RD_LATENCY-1:0]   tag_v;
   logic [RD_LATENCY-1:0]   tag_p;
   logic                    tag_exit;
   logic                    exit_b;

   // ---------------------------------------------------------------
   // Arbitration (combinational)
   // ---------------------------------------------------------------
   always_comb begin
      arb_en  = phy_rdy & ~reset;
      grant_a = arb_en & a_cmd_valid & (~b_cmd_valid | last_b);
      grant_b = arb_en & b_cmd_valid & (~a_cmd_valid | ~last_b);
      grant   = grant_a | grant_b;

      win_rnw     = a_cmd_rnw;
      win_addr    = a_cmd_addr;
      win_wr_data = a_cmd_wr_data;
      win_wr_ben  = a_cmd_wr_ben;
      if (grant_b) begin
         win_rnw     = b_cmd_rnw;
         win_addr    = b_cmd_addr;
         win_wr_data = b_cmd_wr_data;
         win_wr_ben  = b_cmd_wr_ben;
      end
   end

   assign a_cmd_ack = grant_a;
   assign b_cmd_ack = grant_b;

   // ---------------------------------------------------------------
   // Issue register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         last_b      <= 1'b1;
         issued_b    <= 1'b0;
         phy_addr    <= '0;
         phy_wr_data <= '0;
         phy_wr_ben  <= '0;
         phy_wr_strb <= 1'b0;
         phy_rd_strb <= 1'b0;
      end else begin
         phy_wr_strb <= grant & ~win_rnw;
         phy_rd_strb <= grant &  win_rnw;
         if (grant) begin
            last_b      <= grant_b;
            issued_b    <= grant_b;
            phy_addr    <= win_addr;
            phy_wr_data <= win_wr_data;
            phy_wr_ben  <= win_wr_ben;
         end
      end
   end

   // ---------------------------------------------------------------
   // Read tag pipeline: entry loaded from the strobe cycle, exits in
   // the cycle the PHY presents the matching read data.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_v <= '0;
         tag_p <= '0;
      end else begin
         tag_v[0] <= phy_rd_strb;
         tag_p[0] <= issued_b;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_p[i] <= tag_p[i-1];
         end
      end
   end

   assign tag_exit = tag_v[RD_LATENCY-1];
   assign exit_b   = tag_p[RD_LATENCY-1];

   // ---------------------------------------------------------------
   // Read data return (registered, held between pulses)
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         a_rd_data <= '0;
         b_rd_data <= '0;
         a_rd_dvld <= 1'b0;
         b_rd_dvld <= 1'b0;
      end else begin
         a_rd_dvld <= tag_exit & ~exit_b;
         b_rd_dvld <= tag_exit &  exit_b;
         if (tag_exit & ~exit_b) a_rd_data <= phy_rd_data;
         if (tag_exit &  exit_b) b_rd_data <= phy_rd_data;
      end
   end

   // ---------------------------------------------------------------
   // Outstanding read counter
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_inflight <= '0;
      end else begin
         case ({phy_rd_strb, tag_exit})
            2'b10:   rd_inflight <= rd_inflight + CNT_ONE;
            2'b01:   rd_inflight <= rd_inflight - CNT_ONE;
            default: rd_inflight <= rd_inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_qdrc_user_arb.sv
// tb_qdrc_user_arb
//   Bench for qdrc_user_arb: directed scenarios plus randomized traffic,
//   checked every cycle against a transaction-level model (pending-read
//   list with due cycles, round-robin pointer, expected issue fields).
//   A simple PHY model returns address-derived read data RD_LATENCY
//   cycles after each read strobe.
module tb_qdrc_user_arb;
   localparam int DW  = 18;
   localparam int BW  = 2;
   localparam int AW  = 21;
   localparam int LAT = 10;
   localparam int CW  = $clog2(LAT + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, phy_rdy;
   logic              a_cmd_valid, a_cmd_rnw, a_cmd_ack, a_rd_dvld;
   logic [AW-1:0]     a_cmd_addr;
   logic [2*DW-1:0]   a_cmd_wr_data, a_rd_data;
   logic [2*BW-1:0]   a_cmd_wr_ben;
   logic              b_cmd_valid, b_cmd_rnw, b_cmd_ack, b_rd_dvld;
   logic [AW-1:0]     b_cmd_addr;
   logic [2*DW-1:0]   b_cmd_wr_data, b_rd_data;
   logic [2*BW-1:0]   b_cmd_wr_ben;
   logic [AW-1:0]     phy_addr;
   logic              phy_wr_strb, phy_rd_strb;
   logic [2*DW-1:0]   phy_wr_data, phy_rd_data;
   logic [2*BW-1:0]   phy_wr_ben;
   logic [CW-1:0]     rd_inflight;

   qdrc_user_arb #(
      .DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset), .phy_rdy(phy_rdy),
      .a_cmd_valid(a_cmd_valid), .a_cmd_rnw(a_cmd_rnw), .a_cmd_addr(a_cmd_addr),
      .a_cmd_wr_data(a_cmd_wr_data), .a_cmd_wr_ben(a_cmd_wr_ben),
      .a_cmd_ack(a_cmd_ack), .a_rd_data(a_rd_data), .a_rd_dvld(a_rd_dvld),
      .b_cmd_valid(b_cmd_valid), .b_cmd_rnw(b_cmd_rnw), .b_cmd_addr(b_cmd_addr),
      .b_cmd_wr_data(b_cmd_wr_data), .b_cmd_wr_ben(b_cmd_wr_ben),
      .b_cmd_ack(b_cmd_ack), .b_rd_data(b_rd_data), .b_rd_dvld(b_rd_dvld),
      .phy_addr(phy_addr), .phy_wr_strb(phy_wr_strb), .phy_wr_data(phy_wr_data),
      .phy_wr_ben(phy_wr_ben), .phy_rd_strb(phy_rd_strb), .phy_rd_data(phy_rd_data),
      .rd_inflight(rd_inflight)
   );

   typedef struct {
      int              ack;
      int              due;
      bit              port;
      logic [2*DW-1:0] data;
   } rd_t;

   rd_t             pend[$];
   logic [2*DW-1:0] ret_data [int];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit check_en = 1'b0;

   // requester state held by the bench
   logic            rst_i = 1'b1;
   logic            rdy_i = 1'b0;
   logic            req_v   [2];
   logic            req_rnw [2];
   logic [AW-1:0]   req_addr[2];
   logic [2*DW-1:0] req_wd  [2];
   logic [2*BW-1:0] req_ben [2];
   bit              hold_valid = 1'b0;
   bit              auto_gen   = 1'b0;

   // model state
   bit              last_b = 1'b1;
   logic [AW-1:0]   m_addr;
   logic [2*DW-1:0] m_wd;
   logic [2*BW-1:0] m_ben;
   bit              m_wr, m_rd;
   logic [2*DW-1:0] m_rdat[2];

   int cnt_a, cnt_b, cnt_both, cnt_ack, cnt_strb;

   function automatic logic [2*DW-1:0] ret_of(input logic [AW-1:0] a);
      return (36'(a) * 36'd40503) ^ 36'h912345678;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic set_req(input int p, input logic rnw, input logic [AW-1:0] addr,
                          input logic [2*DW-1:0] wd, input logic [2*BW-1:0] ben);
      req_v[p] = 1'b1; req_rnw[p] = rnw; req_addr[p] = addr;
      req_wd[p] = wd; req_ben[p] = ben;
   endtask

   task automatic new_cmd(input int p);
      set_req(p, 1'($urandom_range(0, 1)), AW'($urandom),
              36'({$urandom, $urandom}), 4'($urandom));
   endtask

   task automatic zero_counts();
      cnt_a = 0; cnt_b = 0; cnt_both = 0; cnt_ack = 0; cnt_strb = 0;
   endtask

   task automatic drive();
      reset         = rst_i;
      phy_rdy       = rdy_i;
      a_cmd_valid   = req_v[0];   b_cmd_valid   = req_v[1];
      a_cmd_rnw     = req_rnw[0]; b_cmd_rnw     = req_rnw[1];
      a_cmd_addr    = req_addr[0]; b_cmd_addr   = req_addr[1];
      a_cmd_wr_data = req_wd[0];  b_cmd_wr_data = req_wd[1];
      a_cmd_wr_ben  = req_ben[0]; b_cmd_wr_ben  = req_ben[1];
      if (ret_data.exists(cyc)) begin
         phy_rd_data = ret_data[cyc];
         ret_data.delete(cyc);
      end else begin
         phy_rd_data = 36'({$urandom, $urandom});
      end
   endtask

   // Compare this cycle's outputs with the model, then advance the model.
   task automatic eval();
      bit en, ga, gb;
      bit dv[2];
      int infl;
      en = rdy_i && !rst_i;
      ga = en && req_v[0] && (!req_v[1] || last_b);
      gb = en && req_v[1] && (!req_v[0] || !last_b);
      dv[0] = 1'b0; dv[1] = 1'b0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
         if (pend[i].due == cyc) begin
            dv[pend[i].port] = 1'b1;
            m_rdat[pend[i].port] = pend[i].data;
            pend.delete(i);
         end
      end
      infl = 0;
      foreach (pend[i]) if (pend[i].ack + 2 <= cyc) infl++;

      if (check_en) begin
         chk("a_cmd_ack",   64'(a_cmd_ack),   64'(ga));
         chk("b_cmd_ack",   64'(b_cmd_ack),   64'(gb));
         chk("phy_wr_strb", 64'(phy_wr_strb), 64'(m_wr));
         chk("phy_rd_strb", 64'(phy_rd_strb), 64'(m_rd));
         chk("phy_addr",    64'(phy_addr),    64'(m_addr));
         chk("phy_wr_data", 64'(phy_wr_data), 64'(m_wd));
         chk("phy_wr_ben",  64'(phy_wr_ben),  64'(m_ben));
         chk("a_rd_dvld",   64'(a_rd_dvld),   64'(dv[0]));
         chk("b_rd_dvld",   64'(b_rd_dvld),   64'(dv[1]));
         chk("a_rd_data",   64'(a_rd_data),   64'(m_rdat[0]));
         chk("b_rd_data",   64'(b_rd_data),   64'(m_rdat[1]));
         chk("rd_inflight", 64'(rd_inflight), 64'(infl));
         if (a_rd_dvld === 1'b1) cnt_a++;
         if (b_rd_dvld === 1'b1) cnt_b++;
         if (a_rd_dvld === 1'b1 && b_rd_dvld === 1'b1) cnt_both++;
         if (a_cmd_ack === 1'b1 || b_cmd_ack === 1'b1) cnt_ack++;
         if (phy_wr_strb === 1'b1 || phy_rd_strb === 1'b1) cnt_strb++;
      end

      // PHY model: data appears LAT cycles after the strobe it sees
      if (phy_rd_strb === 1'b1) ret_data[cyc + LAT] = ret_of(phy_addr);

      if (rst_i) begin
         last_b = 1'b1;
         m_addr = '0; m_wd = '0; m_ben = '0; m_wr = 1'b0; m_rd = 1'b0;
         m_rdat[0] = '0; m_rdat[1] = '0;
         pend.delete();
         check_en = 1'b1;
      end else begin
         m_wr = 1'b0; m_rd = 1'b0;
         if (ga || gb) begin
            int p;
            p = gb ? 1 : 0;
            last_b = gb;
            m_addr = req_addr[p]; m_wd = req_wd[p]; m_ben = req_ben[p];
            m_wr = !req_rnw[p]; m_rd = req_rnw[p];
            if (req_rnw[p])
               pend.push_back('{ack: cyc, due: cyc + LAT + 2, port: gb,
                                data: ret_of(req_addr[p])});
         end
      end
      if (ga && !hold_valid) req_v[0] = 1'b0;
      if (gb && !hold_valid) req_v[1] = 1'b0;
      cyc++;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++)
         if (auto_gen && !req_v[p] && $urandom_range(0, 99) < 60) new_cmd(p);
      drive();
      @(negedge clk);
      eval();
   endtask

   task automatic do_reset(input int n);
      rst_i = 1'b1;
      repeat (n) cycle();
      rst_i = 1'b0;
   endtask

   logic [1:0]    ackseq [4];
   logic [AW-1:0] addrseq[4];

   initial begin
      for (int p = 0; p < 2; p++) begin
         req_v[p] = 1'b0; req_rnw[p] = 1'b0; req_addr[p] = '0;
         req_wd[p] = '0; req_ben[p] = '0;
         m_rdat[p] = '0;
      end
      m_addr = '0; m_wd = '0; m_ben = '0; m_wr = 1'b0; m_rd = 1'b0;
      reset = 1'b1; phy_rdy = 1'b0;
      a_cmd_valid = 1'b0; a_cmd_rnw = 1'b0; a_cmd_addr = '0; a_cmd_wr_data = '0; a_cmd_wr_ben = '0;
      b_cmd_valid = 1'b0; b_cmd_rnw = 1'b0; b_cmd_addr = '0; b_cmd_wr_data = '0; b_cmd_wr_ben = '0;
      phy_rd_data = '0;
      zero_counts();

      // reset state
      rdy_i = 1'b1;
      do_reset(2);
      cycle();
      chk("rst_ack",      64'({a_cmd_ack, b_cmd_ack}), 64'h0);
      chk("rst_strb",     64'({phy_wr_strb, phy_rd_strb}), 64'h0);
      chk("rst_inflight", 64'(rd_inflight), 64'h0);
      chk("rst_phy_addr", 64'(phy_addr), 64'h0);

      // single write from A
      set_req(0, 1'b0, 21'h00010, 36'h5A5A5A5A5, 4'hF);
      cycle();
      chk("wr_ack_a", 64'(a_cmd_ack), 64'h1);
      chk("wr_ack_b", 64'(b_cmd_ack), 64'h0);
      cycle();
      chk("wr_strb",   64'(phy_wr_strb), 64'h1);
      chk("wr_rdstrb", 64'(phy_rd_strb), 64'h0);
      chk("wr_addr",   64'(phy_addr),    64'h10);
      chk("wr_data",   64'(phy_wr_data), 64'h5A5A5A5A5);
      chk("wr_ben",    64'(phy_wr_ben),  64'hF);

      // both ports hold reads: grants alternate A,B,A,B
      do_reset(1);
      zero_counts();
      set_req(0, 1'b1, 21'h1, '0, '0);
      set_req(1, 1'b1, 21'h2, '0, '0);
      hold_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (i < 4) ackseq[i] = {a_cmd_ack, b_cmd_ack};
         if (i > 0) addrseq[i-1] = phy_addr;
         if (i == 3) begin
            req_v[0] = 1'b0; req_v[1] = 1'b0; hold_valid = 1'b0;
         end
      end
      chk("rr_ack0", 64'(ackseq[0]), 64'h2);
      chk("rr_ack1", 64'(ackseq[1]), 64'h1);
      chk("rr_ack2", 64'(ackseq[2]), 64'h2);
      chk("rr_ack3", 64'(ackseq[3]), 64'h1);
      chk("rr_addr0", 64'(addrseq[0]), 64'h1);
      chk("rr_addr1", 64'(addrseq[1]), 64'h2);
      chk("rr_addr2", 64'(addrseq[2]), 64'h1);
      chk("rr_addr3", 64'(addrseq[3]), 64'h2);
      cycle();
      chk("rr_inflight_peak", 64'(rd_inflight), 64'h4);
      repeat (12) cycle();
      chk("rr_cnt_a",    64'(cnt_a),    64'h2);
      chk("rr_cnt_b",    64'(cnt_b),    64'h2);
      chk("rr_cnt_both", 64'(cnt_both), 64'h0);
      chk("rr_inflight_end", 64'(rd_inflight), 64'h0);

      // phy_rdy low blocks everything; A first when it returns
      do_reset(1);
      rdy_i = 1'b0;
      zero_counts();
      set_req(0, 1'b1, 21'h11, '0, '0);
      set_req(1, 1'b1, 21'h12, '0, '0);
      repeat (20) cycle();
      chk("rdy_lo_acks",  64'(cnt_ack),  64'h0);
      chk("rdy_lo_strbs", 64'(cnt_strb), 64'h0);
      rdy_i = 1'b1;
      cycle();
      chk("rdy_hi_ack_a", 64'(a_cmd_ack), 64'h1);
      chk("rdy_hi_ack_b", 64'(b_cmd_ack), 64'h0);
      cycle();
      chk("rdy_hi_ack_b2", 64'(b_cmd_ack), 64'h1);
      chk("rdy_hi_addr",   64'(phy_addr),  64'h11);
      repeat (14) cycle();

      // reads return while phy_rdy is low
      zero_counts();
      set_req(0, 1'b1, 21'h3, '0, '0);
      set_req(1, 1'b1, 21'h4, '0, '0);
      cycle();
      cycle();
      set_req(0, 1'b1, 21'h5, '0, '0);
      cycle();
      rdy_i = 1'b0;
      repeat (16) cycle();
      chk("rdylo_ret_a", 64'(cnt_a), 64'h2);
      chk("rdylo_ret_b", 64'(cnt_b), 64'h1);
      chk("rdylo_infl",  64'(rd_inflight), 64'h0);
      rdy_i = 1'b1;

      // reset drops in-flight reads
      zero_counts();
      set_req(0, 1'b1, 21'h6, '0, '0);
      cycle();
      set_req(1, 1'b1, 21'h7, '0, '0);
      cycle();
      cycle();
      cycle();
      rst_i = 1'b1;
      cycle();
      rst_i = 1'b0;
      repeat (15) cycle();
      chk("rstdrop_a",    64'(cnt_a), 64'h0);
      chk("rstdrop_b",    64'(cnt_b), 64'h0);
      chk("rstdrop_infl", 64'(rd_inflight), 64'h0);
      set_req(0, 1'b1, 21'h8, '0, '0);
      cycle();
      repeat (13) cycle();
      chk("post_rst_a", 64'(cnt_a), 64'h1);
      chk("post_rst_b", 64'(cnt_b), 64'h0);
      chk("post_rst_data", 64'(a_rd_data), 64'(ret_of(21'h8)));

      // randomized traffic
      auto_gen = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         rdy_i = ($urandom_range(0, 99) < 85);
         rst_i = ($urandom_range(0, 499) == 0);
         cycle();
      end
      auto_gen = 1'b0;
      rst_i = 1'b0;
      rdy_i = 1'b1;
      repeat (30) cycle();
      chk("final_inflight", 64'(rd_inflight), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
